// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with programmable latency and a one-cycle DataValid pulse.
// The transaction is latched at acceptance; the commit and the read happen on the edge entering RESP.
module dmem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_W    = 16,
   parameter int LATENCY   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRd,
   input  logic              MemWr,
   input  logic [15:0]       Address,
   input  logic [DATA_W-1:0] DataIn,
   output logic [DATA_W-1:0] DataOut,
   output logic              DataValid,
   output logic              Busy,
   output logic              Err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t               state_q;
   logic [3:0]           cnt_q;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]    data_q, data_d, dout_q;
   logic                 wr_q, wr_d, err_q, err_d, valid_q, busy_q, rerr_q;
   logic                 req, enter_resp, unused_addr;
   logic [DATA_W-1:0]    mem [2**ADDR_BITS];
   assign req         = MemRd | MemWr;
   assign unused_addr = ^Address[15:ADDR_BITS];
   // With LATENCY=1 the accepting edge is also the RESP-entry edge, so use the live inputs there.
   assign enter_resp = (state_q == IDLE && req && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd1);
   assign addr_d     = state_q == IDLE ? Address[ADDR_BITS-1:0] : addr_q;
   assign data_d     = state_q == IDLE ? DataIn : data_q;
   assign wr_d       = state_q == IDLE ? MemWr : wr_q;
   assign err_d      = state_q == IDLE ? MemRd & MemWr : err_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         rerr_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req) begin
               addr_q  <= addr_d;
               data_q  <= data_d;
               wr_q    <= wr_d;
               err_q   <= err_d;
               cnt_q   <= 4'(LATENCY - 1);
               busy_q  <= 1'b1;
               state_q <= LATENCY == 1 ? RESP : WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= RESP;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
         valid_q <= enter_resp;
         rerr_q  <= enter_resp & err_d;
         if (enter_resp) dout_q <= wr_d ? data_d : mem[addr_d];
      end
   end
   // Memory is deliberately not reset; rst gating keeps an aborted write from committing.
   always_ff @(posedge clk) begin
      if (rst && enter_resp && wr_d) mem[addr_d] <= data_d;
   end
   assign DataOut   = dout_q;
   assign DataValid = valid_q;
   assign Busy      = busy_q;
   assign Err       = rerr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY=2 (u0) and LATENCY=1 (u1).
module tb_dmem_responder;
   logic        clk = 1'b0, rst = 1'b0, MemRd = 1'b0, MemWr = 1'b0;
   logic [15:0] Address = '0, DataIn = '0;
   logic [15:0] dout0, dout1;
   logic        valid0, busy0, err0, valid1, busy1, err1;
   int          errors = 0, checks = 0;

   dmem_responder #(.ADDR_BITS(8), .DATA_W(16), .LATENCY(2)) u0 (
      .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .Address(Address), .DataIn(DataIn),
      .DataOut(dout0), .DataValid(valid0), .Busy(busy0), .Err(err0));
   dmem_responder #(.ADDR_BITS(8), .DATA_W(16), .LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .Address(Address), .DataIn(DataIn),
      .DataOut(dout1), .DataValid(valid1), .Busy(busy1), .Err(err1));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One LATENCY=2 transaction on u0: request for one edge, response two edges after acceptance.
   task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp, input logic exp_err, input string tag);
      MemRd = rd; MemWr = wr; Address = a; DataIn = d;
      step();
      MemRd = 1'b0; MemWr = 1'b0;
      chk({tag, "_wait_busy"}, busy0, 1);
      chk({tag, "_wait_valid"}, valid0, 0);
      step();
      chk({tag, "_valid"}, valid0, 1);
      chk({tag, "_dout"}, dout0, exp);
      chk({tag, "_err"}, err0, exp_err);
      step();
      chk({tag, "_after_valid"}, valid0, 0);
      chk({tag, "_after_busy"}, busy0, 0);
      chk({tag, "_hold_dout"}, dout0, exp);
   endtask

   initial begin
      step();
      step();
      chk("rst_dout", dout0, 0);
      chk("rst_valid", valid0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_err", err0, 0);
      chk("rst_busy1", busy1, 0);
      rst = 1'b1;
      step();
      // write then read back
      txn(1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'hBEEF, 1'b0, "wr5");
      txn(1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, "rd5");
      // inputs ignored while busy
      txn(1'b0, 1'b1, 16'h0009, 16'hCAFE, 16'hCAFE, 1'b0, "wr9");
      MemWr = 1'b1; Address = 16'h0007; DataIn = 16'h1357;
      step();
      Address = 16'h0009; DataIn = 16'h1234;
      step();
      MemWr = 1'b0;
      chk("ign_valid", valid0, 1);
      chk("ign_dout", dout0, 16'h1357);
      step();
      txn(1'b1, 1'b0, 16'h0009, 16'h0000, 16'hCAFE, 1'b0, "ign_rd9");
      txn(1'b1, 1'b0, 16'h0007, 16'h0000, 16'h1357, 1'b0, "ign_rd7");
      // address wrap
      txn(1'b0, 1'b1, 16'h0103, 16'h00AA, 16'h00AA, 1'b0, "wrap_wr");
      txn(1'b1, 1'b0, 16'h0003, 16'h0000, 16'h00AA, 1'b0, "wrap_rd");
      // both requests: write with Err
      txn(1'b1, 1'b1, 16'h0010, 16'h5A5A, 16'h5A5A, 1'b1, "both");
      txn(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h5A5A, 1'b0, "both_rd");
      // reset abort of an uncommitted write
      txn(1'b0, 1'b1, 16'h0020, 16'h1111, 16'h1111, 1'b0, "pre_wr");
      MemWr = 1'b1; Address = 16'h0020; DataIn = 16'h7777;
      step();
      MemWr = 1'b0;
      chk("abort_busy_pre", busy0, 1);
      rst = 1'b0;
      #1;
      chk("abort_busy", busy0, 0);
      chk("abort_valid", valid0, 0);
      chk("abort_dout", dout0, 0);
      step();
      chk("abort_novalid", valid0, 0);
      step();
      rst = 1'b1;
      step();
      chk("abort_idle_valid", valid0, 0);
      txn(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, "abort_rd");
      // held read: u0 responds every 3 cycles, u1 every 2
      MemRd = 1'b1; Address = 16'h0005;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk($sformatf("held_valid0_%0d", i), valid0, (i % 3) == 2);
         chk($sformatf("held_busy0_%0d", i), busy0, (i % 3) != 0);
         chk($sformatf("held_valid1_%0d", i), valid1, (i % 2) == 1);
         chk($sformatf("held_busy1_%0d", i), busy1, (i % 2) == 1);
      end
      MemRd = 1'b0;
      chk("held_dout0", dout0, 16'hBEEF);
      chk("held_dout1", dout1, 16'hBEEF);
      step();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the CPU's memory-stage requests.
- Sits opposite the pipeline's MEM stage. It receives MemRd/MemWr, Address and DataIn, performs the access after a programmable latency, and returns DataOut with a one-cycle DataValid pulse.
- Lets the pipeline be exercised against a realistic multi-cycle memory instead of a zero-latency array.

Parameters:
- ADDR_BITS, 8, number of low address bits used; depth = 2^ADDR_BITS words.
- DATA_W, 16, data word width.
- LATENCY, 2, cycles from request acceptance to DataValid; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- MemRd  input  1  read request, level-sensitive.
- MemWr  input  1  write request, level-sensitive.
- Address  input  16  word address; only bits [ADDR_BITS-1:0] are used.
- DataIn  input  DATA_W  write data.
- DataOut  output  DATA_W  read data, or echoed write data, for the current response.
- DataValid  output  1  one-cycle pulse marking the response cycle.
- Busy  output  1  high while a transaction is in flight (WAIT or RESP).
- Err  output  1  high with DataValid when MemRd and MemWr were both high at acceptance.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, DataOut=0, DataValid=0, Busy=0, Err=0, counter=0.
  - Memory array contents are not cleared.
- States:
  - IDLE: on a rising edge with (MemRd|MemWr)=1, accept the request.
    - Latch Address[ADDR_BITS-1:0], DataIn, an op bit (write if MemWr=1), and err = MemRd&MemWr.
    - Load counter = LATENCY-1.
    - Go to WAIT, or straight to RESP if LATENCY=1.
  - WAIT: decrement the counter each edge; go to RESP on the edge where the counter reaches 0.
    - MemRd, MemWr, Address and DataIn are ignored; latched values are used.
  - RESP: DataValid=1 and Err=latched err for exactly this one cycle; next edge returns to IDLE.
    - A request sampled on that same edge is not accepted; acceptance only happens from IDLE.
- Timing:
  - DataValid is high in the cycle after the LATENCY-th rising edge, counting the accepting edge as edge 1.
  - Back-to-back transactions are therefore spaced LATENCY+1 cycles apart.
- Read: DataOut = mem[latched addr], registered on the edge entering RESP.
- Write:
  - mem[latched addr] <= latched data on the edge entering RESP.
  - DataOut = latched write data in RESP.
  - A read issued in the following transaction returns the new value.
- Simultaneous MemRd and MemWr: treated as a write, with Err=1 in RESP.
- Address wrap: upper address bits are ignored, so address 0x0100 aliases 0x0000 when ADDR_BITS=8.
- DataOut holds its RESP value through IDLE and WAIT until the next response. DataValid stays 0 outside RESP.
- Busy=1 in WAIT and RESP, 0 in IDLE.
- Reset mid-transaction: the transaction is aborted. A write not yet committed (reset before the RESP-entry edge) must not change memory. No DataValid is issued.
- Request held high after RESP: re-accepted in IDLE as a new transaction. The initiator must drop its request on DataValid to get a single access.

Test Plan (LATENCY=2, ADDR_BITS=8):
1. Write/read back:
   - MemWr=1, Address=0x0005, DataIn=0xBEEF for 1 cycle -> DataValid pulses 2 edges later, DataOut=0xBEEF, Err=0.
   - Then MemRd=1 at 0x0005 -> DataOut=0xBEEF with DataValid 2 edges after acceptance.
2. Inputs ignored while busy: during WAIT, change Address to 0x0009 and DataIn to 0x1234 -> the committed write still goes to the originally latched address/data.
   - Read 0x0009 -> old value; read the original address -> original data.
3. Wrap: write 0x00AA to Address 0x0103 -> read of 0x0003 returns 0x00AA.
4. Both requests: MemRd=MemWr=1, Address=0x0010, DataIn=0x5A5A -> DataValid with Err=1.
   - Subsequent read of 0x0010 returns 0x5A5A.
5. Reset abort: accept a write of 0x7777 to 0x0020 (location previously 0x1111), pull rst low during WAIT -> DataValid/Busy drop immediately, no pulse.
   - After release, read 0x0020 returns 0x1111.
6. Held request and latency sweep:
   - MemRd held high continuously -> DataValid every 3 cycles, Busy low exactly 1 cycle between transactions.
   - Repeat with LATENCY=1 -> DataValid every 2 cycles.
